// File: rtl/spi_regfile_pkg.sv
// Shared types and constants for the SPI register-file peripheral.
`timescale 1ns/1ps
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHIFT   = 2'd1,
    WAIT_HI = 2'd2
  } state_t;

  localparam logic RW_WRITE  = 1'b1;
  localparam int   ERR_CNT_W = 8;

  function automatic int frame_w(input int addr_w, input int data_w);
    return 1 + addr_w + data_w;
  endfunction

endpackage

// File: rtl/spi_regfile_if.sv
// SPI pins between a controller and the register-file peripheral.
`timescale 1ns/1ps
interface spi_regfile_if;
  logic sclk;
  logic copi;
  logic ncs;
  logic cipo;
  logic cipo_oe;

  modport master (output sclk, output copi, output ncs, input cipo, input cipo_oe);
  modport slave  (input sclk, input copi, input ncs, output cipo, output cipo_oe);
endinterface

// File: rtl/spi_regfile_sync.sv
// Multi-flop synchroniser for one asynchronous input, with rise/fall pulses
// from an extra edge-detect flop. Resets to the pin's idle level.
`timescale 1ns/1ps
module spi_sync #(
  parameter int   STAGES   = 2,
  parameter logic IDLE_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain_q;
  logic              last_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain_q <= {STAGES{IDLE_VAL}};
      last_q  <= IDLE_VAL;
    end else begin
      chain_q <= {chain_q[STAGES-2:0], d};
      last_q  <= chain_q[STAGES-1];
    end
  end

  assign q    = chain_q[STAGES-1];
  assign rise = q & ~last_q;
  assign fall = ~q & last_q;

endmodule

// File: rtl/spi_regfile.sv
// SPI mode-0 register file: write/read frames of {R/W, addr, data}, strict
// length checking, write strobe and saturating rejected-frame counter.
//
// state   | meaning
// IDLE    | waiting for ncs to fall
// SHIFT   | frame in progress, sampling copi and driving read data on cipo
// WAIT_HI | after reset, waiting for the synchronisers to settle and ncs high
`timescale 1ns/1ps
module spi_regfile
  import spi_pkg::*;
#(
  parameter int NUM_REGS    = 8,
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 7,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  spi_regfile_if.slave               spi,
  output logic [NUM_REGS*DATA_W-1:0] regs_flat,
  output logic                       wr_stb,
  output logic [ADDR_W-1:0]          wr_addr,
  output logic [ERR_CNT_W-1:0]       err_cnt
);

  localparam int FRAME_W  = frame_w(ADDR_W, DATA_W);
  localparam int BC_W     = $clog2(FRAME_W + 2);
  localparam int SETTLE_W = $clog2(SYNC_STAGES + 2);

  localparam logic [BC_W-1:0] BC_ADDR_LAST  = BC_W'(ADDR_W);
  localparam logic [BC_W-1:0] BC_DATA_START = BC_W'(1 + ADDR_W);
  localparam logic [BC_W-1:0] BC_FRAME      = BC_W'(FRAME_W);
  localparam logic [BC_W-1:0] BC_SAT        = BC_W'(FRAME_W + 1);

  logic sclk_q, sclk_rise, sclk_fall;
  logic copi_q, copi_rise, copi_fall;
  logic ncs_q, ncs_rise, ncs_fall;

  spi_sync #(.STAGES(SYNC_STAGES), .IDLE_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst(rst), .d(spi.sclk), .q(sclk_q), .rise(sclk_rise), .fall(sclk_fall)
  );
  spi_sync #(.STAGES(SYNC_STAGES), .IDLE_VAL(1'b0)) u_sync_copi (
    .clk(clk), .rst(rst), .d(spi.copi), .q(copi_q), .rise(copi_rise), .fall(copi_fall)
  );
  spi_sync #(.STAGES(SYNC_STAGES), .IDLE_VAL(1'b1)) u_sync_ncs (
    .clk(clk), .rst(rst), .d(spi.ncs), .q(ncs_q), .rise(ncs_rise), .fall(ncs_fall)
  );

  logic unused_sync;
  assign unused_sync = ^{sclk_q, copi_rise, copi_fall};

  state_t               state_q, state_d;
  logic [BC_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [FRAME_W-1:0]   shift_q, shift_d;
  logic [DATA_W-1:0]    tx_q, tx_d;
  logic                 oe_q, oe_d;
  logic [SETTLE_W-1:0]  settle_q;
  logic [DATA_W-1:0]    regs_q [NUM_REGS];
  logic                 wr_stb_q;
  logic [ADDR_W-1:0]    wr_addr_q;
  logic [ERR_CNT_W-1:0] err_cnt_q;
  logic                 commit, reject;

  // Header as it will look once the current sclk rise lands: {R/W, addr}.
  logic [ADDR_W:0]      hdr;
  logic [ADDR_W-1:0]    hdr_addr;
  logic [DATA_W-1:0]    rd_data;

  logic                 fr_rw;
  logic [ADDR_W-1:0]    fr_addr;
  logic [DATA_W-1:0]    fr_data;
  logic                 frame_ok;
  logic                 wr_in_range;

  assign hdr         = {shift_q[ADDR_W-1:0], copi_q};
  assign hdr_addr    = hdr[ADDR_W-1:0];
  assign fr_rw       = shift_q[FRAME_W-1];
  assign fr_addr     = shift_q[DATA_W +: ADDR_W];
  assign fr_data     = shift_q[DATA_W-1:0];
  assign frame_ok    = (bit_cnt_q == BC_FRAME);
  assign wr_in_range = ({1'b0, fr_addr} < (ADDR_W+1)'(NUM_REGS));

  // Out-of-range addresses match no register and read back as zero.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (hdr_addr == ADDR_W'(i)) rd_data = regs_q[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= WAIT_HI;
    else     state_q <= state_d;
  end

  // An ncs edge wins over an sclk edge detected in the same cycle.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    oe_d      = oe_q;
    commit    = 1'b0;
    reject    = 1'b0;
    case (state_q)
      IDLE: begin
        if (ncs_fall) begin
          state_d   = SHIFT;
          bit_cnt_d = '0;
          shift_d   = '0;
          tx_d      = '0;
          oe_d      = 1'b0;
        end
      end
      SHIFT: begin
        if (ncs_rise) begin
          state_d = IDLE;
          tx_d    = '0;
          oe_d    = 1'b0;
          if (frame_ok && fr_rw == RW_WRITE && wr_in_range) begin
            commit = 1'b1;
          end else if (!frame_ok || fr_rw == RW_WRITE) begin
            reject = 1'b1;
          end
        end else if (sclk_rise) begin
          shift_d = {shift_q[FRAME_W-2:0], copi_q};
          if (bit_cnt_q != BC_SAT) bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == BC_ADDR_LAST && hdr[ADDR_W] != RW_WRITE) begin
            tx_d = rd_data;
            oe_d = 1'b1;
          end
        end else if (sclk_fall && oe_q && bit_cnt_q > BC_DATA_START) begin
          // MSB must survive the fall before the first data rise.
          tx_d = {tx_q[DATA_W-2:0], 1'b0};
        end
      end
      WAIT_HI: begin
        if (settle_q == '0 && ncs_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt_q <= '0;
      shift_q   <= '0;
      tx_q      <= '0;
      oe_q      <= 1'b0;
    end else begin
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      oe_q      <= oe_d;
    end
  end

  // Reset values in the synchronisers are not real pin levels; ignore them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 settle_q <= SETTLE_W'(SYNC_STAGES + 1);
    else if (settle_q != '0) settle_q <= settle_q - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      wr_stb_q  <= 1'b0;
      wr_addr_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (commit && fr_addr == ADDR_W'(i)) regs_q[i] <= fr_data;
      end
      wr_stb_q <= commit;
      if (commit) wr_addr_q <= fr_addr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt_q <= '0;
    end else if (reject && err_cnt_q != {ERR_CNT_W{1'b1}}) begin
      err_cnt_q <= err_cnt_q + 1'b1;
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign regs_flat[g*DATA_W +: DATA_W] = regs_q[g];
  end

  assign spi.cipo    = tx_q[DATA_W-1];
  assign spi.cipo_oe = oe_q & ~ncs_rise;
  assign wr_stb      = wr_stb_q;
  assign wr_addr     = wr_addr_q;
  assign err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_spi_regfile.sv
// Directed bench for spi_regfile: expected writes, reads and error counts are
// queued by the driver and matched by independent monitors.
`timescale 1ns/1ps
module tb_spi_regfile;

  localparam int HALF = 8;
  localparam int GAP  = 10;

  logic        clk;
  logic        rst;
  logic [63:0] regs_flat;
  logic        wr_stb;
  logic [6:0]  wr_addr;
  logic [7:0]  err_cnt;

  spi_regfile_if spi_bus ();

  spi_regfile dut (
    .clk       (clk),
    .rst       (rst),
    .spi       (spi_bus),
    .regs_flat (regs_flat),
    .wr_stb    (wr_stb),
    .wr_addr   (wr_addr),
    .err_cnt   (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0]  addr;
    logic [63:0] regs;
  } wexp_t;

  wexp_t      wq[$];
  logic [7:0] rq[$];
  logic [7:0] eq[$];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    spi_bus.copi = b;
    wait_clks(HALF);
    spi_bus.sclk = 1'b1;
    wait_clks(HALF);
    spi_bus.sclk = 1'b0;
  endtask

  // coincide: final sclk rise and ncs rise happen at the same instant.
  task automatic spi_frame(input logic [31:0] bits, input int n, input bit coincide);
    spi_bus.ncs = 1'b0;
    wait_clks(HALF);
    for (int i = n - 1; i >= 0; i--) begin
      if (coincide && i == 0) begin
        spi_bus.copi = bits[i];
        wait_clks(HALF);
        spi_bus.sclk = 1'b1;
        spi_bus.ncs  = 1'b1;
        wait_clks(HALF);
        spi_bus.sclk = 1'b0;
      end else begin
        send_bit(bits[i]);
      end
    end
    if (!coincide) begin
      wait_clks(HALF);
      spi_bus.ncs = 1'b1;
    end
    spi_bus.copi = 1'b0;
    wait_clks(GAP);
  endtask

  task automatic drained(input string tag);
    check({tag, "_wq_empty"}, 64'(wq.size()), 64'd0);
    check({tag, "_rq_empty"}, 64'(rq.size()), 64'd0);
    check({tag, "_eq_empty"}, 64'(eq.size()), 64'd0);
  endtask

  // Write monitor: every strobe must match a queued write and last one cycle.
  initial begin
    wexp_t e;
    forever begin
      @(negedge clk);
      if (!rst && wr_stb) begin
        check("wr_expected", 64'(wq.size() != 0), 64'd1);
        if (wq.size() != 0) begin
          e = wq.pop_front();
          check("wr_addr", 64'(wr_addr), 64'(e.addr));
          check("wr_regs", regs_flat, e.regs);
          @(negedge clk);
          check("wr_stb_one_cycle", 64'(wr_stb), 64'd0);
        end
      end
    end
  end

  // Error monitor: every change of err_cnt must match a queued value.
  logic [7:0] err_prev;
  initial begin
    err_prev = 8'd0;
    forever begin
      @(negedge clk);
      if (rst) begin
        err_prev = err_cnt;
      end else if (err_cnt !== err_prev) begin
        check("err_expected", 64'(eq.size() != 0), 64'd1);
        if (eq.size() != 0) check("err_cnt", 64'(err_cnt), 64'(eq.pop_front()));
        err_prev = err_cnt;
      end
    end
  end

  // Read capture: cipo is sampled on each sclk rise while cipo_oe is high.
  int         rise_idx;
  int         first_oe;
  int         rd_n;
  logic [7:0] rd_bits;
  initial begin
    rise_idx = 0; first_oe = 0; rd_n = 0; rd_bits = 8'd0;
    forever begin
      @(posedge spi_bus.sclk or negedge spi_bus.ncs);
      if (!spi_bus.sclk) begin
        rise_idx = 0; first_oe = 0; rd_n = 0; rd_bits = 8'd0;
      end else begin
        rise_idx++;
        if (spi_bus.cipo_oe) begin
          if (first_oe == 0) first_oe = rise_idx;
          rd_bits = {rd_bits[6:0], spi_bus.cipo};
          rd_n++;
        end
      end
    end
  end

  // Read checker: fires when cipo_oe drops at the end of a read frame.
  logic prev_oe;
  initial begin
    prev_oe = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_oe = 1'b0;
      end else begin
        if (prev_oe && !spi_bus.cipo_oe) begin
          check("rd_expected", 64'(rq.size() != 0), 64'd1);
          if (rq.size() != 0) begin
            check("rd_data", 64'(rd_bits), 64'(rq.pop_front()));
            check("rd_bit_count", 64'(rd_n), 64'd8);
            check("oe_first_rise", 64'(first_oe), 64'd9);
            check("oe_drop_after_ncs", 64'(spi_bus.ncs), 64'd1);
          end
        end
        prev_oe = spi_bus.cipo_oe;
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog time limit reached checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  int          exp_err;
  logic [31:0] fbits;

  initial begin
    spi_bus.sclk = 1'b0;
    spi_bus.copi = 1'b0;
    spi_bus.ncs  = 1'b1;
    rst = 1'b1;
    wait_clks(5);
    rst = 1'b0;
    wait_clks(10);

    check("rst_regs", regs_flat, 64'd0);
    check("rst_wr_stb", 64'(wr_stb), 64'd0);
    check("rst_wr_addr", 64'(wr_addr), 64'd0);
    check("rst_err_cnt", 64'(err_cnt), 64'd0);
    check("rst_cipo", 64'(spi_bus.cipo), 64'd0);
    check("rst_cipo_oe", 64'(spi_bus.cipo_oe), 64'd0);

    // Write 0xA5 to register 3.
    wq.push_back('{addr: 7'd3, regs: 64'h0000_0000_A500_0000});
    spi_frame(32'h83A5, 16, 1'b0);
    drained("w3");
    check("w3_regs", regs_flat, 64'h0000_0000_A500_0000);
    check("w3_err", 64'(err_cnt), 64'd0);

    // Write 0x3C to register 5, then read it back.
    wq.push_back('{addr: 7'd5, regs: 64'h0000_3C00_A500_0000});
    spi_frame(32'h853C, 16, 1'b0);
    rq.push_back(8'h3C);
    spi_frame(32'h0500, 16, 1'b0);
    drained("rd5");
    check("rd5_regs", regs_flat, 64'h0000_3C00_A500_0000);
    check("rd5_wr_addr", 64'(wr_addr), 64'd5);
    check("rd5_cipo_oe_idle", 64'(spi_bus.cipo_oe), 64'd0);

    // Short and long frames are rejected.
    eq.push_back(8'd1);
    spi_frame(32'h083A, 12, 1'b0);
    eq.push_back(8'd2);
    spi_frame(32'h1074B, 17, 1'b0);
    drained("len");
    check("len_regs", regs_flat, 64'h0000_3C00_A500_0000);

    // Out-of-range write is rejected; out-of-range read returns zero.
    eq.push_back(8'd3);
    spi_frame(32'h8977, 16, 1'b0);
    rq.push_back(8'h00);
    spi_frame(32'h0900, 16, 1'b0);
    drained("oor");
    check("oor_regs", regs_flat, 64'h0000_3C00_A500_0000);
    check("oor_err", 64'(err_cnt), 64'd3);
    check("oor_wr_addr", 64'(wr_addr), 64'd5);

    // Reset in the middle of a frame with ncs held low.
    fbits = 32'h825A;
    spi_bus.ncs = 1'b0;
    wait_clks(HALF);
    for (int i = 15; i >= 10; i--) send_bit(fbits[i]);
    rst = 1'b1;
    wait_clks(3);
    rst = 1'b0;
    wait_clks(2);
    check("mid_rst_regs", regs_flat, 64'd0);
    check("mid_rst_err", 64'(err_cnt), 64'd0);
    check("mid_rst_wr_addr", 64'(wr_addr), 64'd0);
    check("mid_rst_wr_stb", 64'(wr_stb), 64'd0);
    check("mid_rst_cipo", 64'(spi_bus.cipo), 64'd0);
    check("mid_rst_cipo_oe", 64'(spi_bus.cipo_oe), 64'd0);
    for (int i = 9; i >= 0; i--) send_bit(fbits[i]);
    wait_clks(HALF);
    spi_bus.ncs  = 1'b1;
    spi_bus.copi = 1'b0;
    wait_clks(GAP);
    drained("tail");
    check("tail_regs", regs_flat, 64'd0);
    check("tail_err", 64'(err_cnt), 64'd0);
    wq.push_back('{addr: 7'd2, regs: 64'h0000_0000_005A_0000});
    spi_frame(32'h825A, 16, 1'b0);
    drained("post_rst");
    check("post_rst_regs", regs_flat, 64'h0000_0000_005A_0000);

    // ncs rise coincident with the 16th sclk rise: short frame.
    eq.push_back(8'd1);
    spi_frame(32'h8111, 16, 1'b1);
    drained("coin");
    check("coin_regs", regs_flat, 64'h0000_0000_005A_0000);
    check("coin_wr_addr", 64'(wr_addr), 64'd2);

    // Error counter saturation.
    exp_err = 1;
    for (int k = 0; k < 300; k++) begin
      if (exp_err < 255) begin
        exp_err++;
        eq.push_back(8'(exp_err));
      end
      spi_frame(32'h0, 0, 1'b0);
    end
    drained("sat");
    check("sat_err", 64'(err_cnt), 64'd255);
    check("sat_regs", regs_flat, 64'h0000_0000_005A_0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
